// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: block codes, FSM states, playfield size and the
// per-rotation footprint lookup used by the piece controller and the renderer.
package tetris_pkg;

  localparam int unsigned DEFAULT_COLS = 32'd10;
  localparam int unsigned DEFAULT_ROWS = 32'd20;

  typedef enum logic [2:0] {
    I_BLOCK = 3'b000,
    O_BLOCK = 3'b001,
    T_BLOCK = 3'b010,
    S_BLOCK = 3'b011,
    Z_BLOCK = 3'b100,
    J_BLOCK = 3'b101,
    L_BLOCK = 3'b110
  } block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SPAWN = 2'b01,
    FALL  = 2'b10,
    LOCK  = 2'b11
  } state_t;

  typedef struct packed {
    logic [2:0] w;
    logic [2:0] h;
  } footprint_t;

  // Bounding box of a block in cells; odd rotations swap width and height.
  function automatic footprint_t footprint(input logic [2:0] blk, input logic [1:0] r);
    footprint_t fp;
    case (blk)
      I_BLOCK: begin
        fp.w = r[0] ? 3'd1 : 3'd4;
        fp.h = r[0] ? 3'd4 : 3'd1;
      end
      O_BLOCK: begin
        fp.w = 3'd2;
        fp.h = 3'd2;
      end
      default: begin
        fp.w = r[0] ? 3'd2 : 3'd3;
        fp.h = r[0] ? 3'd3 : 3'd2;
      end
    endcase
    return fp;
  endfunction

endpackage

// File: rtl/drop_timer.sv
// Gravity timer: counts pclk cycles while running and flags the cycle in which
// the selected period (normal or soft-drop) elapses.
module drop_timer #(
  parameter int unsigned DROP_TICKS = 32'd32_500_000,
  parameter int unsigned SOFT_TICKS = 32'd3_250_000
) (
  input  logic pclk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  input  logic soft_drop,
  output logic tick
);

  logic [31:0] cnt_r;
  logic [31:0] limit_s;

  // Period select; >= lets a late soft_drop fire immediately.
  always_comb begin
    if (soft_drop) begin
      limit_s = SOFT_TICKS - 32'd1;
    end else begin
      limit_s = DROP_TICKS - 32'd1;
    end
    tick = run && !clr && (cnt_r >= limit_s);
  end

  // Cycle counter, restarted on clear and on each elapsed period.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      cnt_r <= 32'd0;
    end else if (clr) begin
      cnt_r <= 32'd0;
    end else if (run) begin
      if (cnt_r >= limit_s) begin
        cnt_r <= 32'd0;
      end else begin
        cnt_r <= cnt_r + 32'd1;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/piece_ctl.sv
// Falling-piece controller: spawns blocks, applies moves/rotation with wall
// checks, drives gravity from drop_timer and pulses lock on landing.
module piece_ctl
  import tetris_pkg::*;
#(
  parameter int unsigned COLS       = DEFAULT_COLS,
  parameter int unsigned ROWS       = DEFAULT_ROWS,
  parameter int unsigned DROP_TICKS = 32'd32_500_000,
  parameter int unsigned SOFT_TICKS = 32'd3_250_000,
  parameter int unsigned SPAWN_COL  = 32'd3
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        start,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        rotate,
  input  logic        soft_drop,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic [2:0]  block,
  output logic [2:0]  rot,
  output logic        piece_active,
  output logic        lock_pulse
);

  localparam logic [11:0] COLS_W  = 12'(COLS);
  localparam logic [11:0] ROWS_W  = 12'(ROWS);
  localparam logic [11:0] SPAWN_X = 12'(SPAWN_COL);

  state_t     state_r;
  logic [2:0] blk_cnt_r;
  logic [1:0] rot_r;
  logic       pending_r;
  logic       tick_s;
  logic       tmr_clr_s;
  logic       tmr_run_s;
  logic       cmd_s;
  footprint_t fp_cur_s;
  footprint_t fp_next_s;
  logic       rot_ok_s;
  logic       left_ok_s;
  logic       right_ok_s;
  logic       floor_ok_s;

  assign rot = {1'b0, rot_r};

  // Legality of each candidate move against the walls and floor.
  always_comb begin
    fp_cur_s   = footprint(block, rot_r);
    fp_next_s  = footprint(block, rot_r + 2'd1);
    rot_ok_s   = ((xpos + {9'd0, fp_next_s.w}) <= COLS_W) &&
                 ((ypos + {9'd0, fp_next_s.h}) <= ROWS_W);
    left_ok_s  = (xpos != 12'd0);
    right_ok_s = ((xpos + {9'd0, fp_cur_s.w} + 12'd1) <= COLS_W);
    floor_ok_s = ((ypos + {9'd0, fp_cur_s.h} + 12'd1) <= ROWS_W);
    cmd_s      = rotate || move_left || move_right;
    tmr_clr_s  = (state_r == SPAWN);
    tmr_run_s  = (state_r == FALL);
  end

  drop_timer #(
    .DROP_TICKS (DROP_TICKS),
    .SOFT_TICKS (SOFT_TICKS)
  ) u_drop_timer (
    .pclk      (pclk),
    .rst       (rst),
    .clr       (tmr_clr_s),
    .run       (tmr_run_s),
    .soft_drop (soft_drop),
    .tick      (tick_s)
  );

  // Free-running block selector, sampled at spawn.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      blk_cnt_r <= 3'd0;
    end else if (blk_cnt_r == 3'd6) begin
      blk_cnt_r <= 3'd0;
    end else begin
      blk_cnt_r <= blk_cnt_r + 3'd1;
    end
  end

  // Piece FSM with registered position and status outputs.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      xpos         <= 12'd0;
      ypos         <= 12'd0;
      block        <= 3'd0;
      rot_r        <= 2'd0;
      pending_r    <= 1'b0;
      piece_active <= 1'b0;
      lock_pulse   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          piece_active <= 1'b0;
          lock_pulse   <= 1'b0;
          state_r      <= start ? SPAWN : IDLE;
        end
        SPAWN: begin
          block        <= blk_cnt_r;
          xpos         <= SPAWN_X;
          ypos         <= 12'd0;
          rot_r        <= 2'd0;
          pending_r    <= 1'b0;
          piece_active <= 1'b1;
          lock_pulse   <= 1'b0;
          state_r      <= FALL;
        end
        FALL: begin
          lock_pulse <= 1'b0;
          if (cmd_s) begin
            // Strict priority: only the highest pending command is considered.
            if (rotate) begin
              if (rot_ok_s) rot_r <= rot_r + 2'd1;
            end else if (move_left) begin
              if (left_ok_s) xpos <= xpos - 12'd1;
            end else begin
              if (right_ok_s) xpos <= xpos + 12'd1;
            end
            if (tick_s) pending_r <= 1'b1;
          end else if (pending_r) begin
            if (floor_ok_s) begin
              ypos      <= ypos + 12'd1;
              pending_r <= tick_s;
            end else begin
              pending_r    <= 1'b0;
              piece_active <= 1'b0;
              lock_pulse   <= 1'b1;
              state_r      <= LOCK;
            end
          end else begin
            if (tick_s) pending_r <= 1'b1;
          end
        end
        LOCK: begin
          lock_pulse   <= 1'b0;
          piece_active <= 1'b0;
          state_r      <= SPAWN;
        end
        default: begin
          state_r      <= IDLE;
          piece_active <= 1'b0;
          lock_pulse   <= 1'b0;
        end
      endcase
    end
  end

endmodule
